// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sprite word layout, vblank line, motion limit, DMA state encoding.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package ppu_pkg;

    // Sprite word layout: {palette[31:24], tile[23:16], y[15:8], x[7:0]}
    localparam int SPR_X_LSB    = 0;
    localparam int SPR_Y_LSB    = 8;
    localparam int SPR_TILE_LSB = 16;
    localparam int SPR_PAL_LSB  = 24;

    typedef struct packed {
        logic [7:0] pal;
        logic [7:0] tile;
        logic [7:0] y;
        logic [7:0] x;
    } sprite_t;

    localparam logic [9:0] VBLANK_LINE = 10'd480;
    localparam logic [7:0] X_MAX       = 8'd248;

    // Initial sprite table: x = 16 + 32*i (mod 256), y = 100, tile = i, palette = 1
    localparam logic [7:0] INIT_X0  = 8'd16;
    localparam logic [7:0] INIT_Y   = 8'd100;
    localparam logic [7:0] INIT_PAL = 8'd1;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_MOVE   = 2'd3
    } dma_state_e;

    // Shadow motion state of one sprite; neg = 1 means moving left (dir -1)
    typedef struct packed {
        logic       neg;
        logic [7:0] x;
    } motion_t;

    // One frame of bouncing motion between 0 and X_MAX
    function automatic motion_t next_motion(input motion_t cur);
        motion_t nxt;
        nxt = cur;
        if (!cur.neg) begin
            if (cur.x == X_MAX) begin
                nxt.x   = X_MAX - 8'd1;
                nxt.neg = 1'b1;
            end else begin
                nxt.x = cur.x + 8'd1;
            end
        end else begin
            if (cur.x == 8'd0) begin
                nxt.x   = 8'd1;
                nxt.neg = 1'b0;
            end else begin
                nxt.x = cur.x - 8'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sprite_init_rom.sv
// Initial sprite table: sprite index -> 32-bit OAM word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: idx_i (sprite index 0..63), word_o (initial sprite word).
module sprite_init_rom
    import ppu_pkg::*;
(
    input  logic [5:0]  idx_i,
    output logic [31:0] word_o
);

    sprite_t w;

    always_comb begin
        w      = '0;
        w.pal  = INIT_PAL;
        w.tile = {2'b00, idx_i};
        w.y    = INIT_Y;
        // 32*i mod 256 only depends on the low three index bits
        w.x    = INIT_X0 + {idx_i[2:0], 5'b00000};
        word_o = w;
    end

endmodule

// File: rtl/oam_dma_sequencer.sv
// Sprite OAM sequencer: waits out power-up, writes the initial sprite table, then on every
// vblank (with anim_en) bounces each sprite one pixel and rewrites its word.
// Latency: first write SETTLE_CYCLES cycles after reset release; MOVE burst starts the cycle
// after the vblank edge. Backpressure: none, one word per cycle; vblanks while busy are dropped.
// Ports: clock_25/reset (async active-low), vCount/anim_en in; cpu_oam_data/addr/write,
// busy, frame_cnt out (all registered).
module oam_dma_sequencer
    import ppu_pkg::*;
#(
    parameter int NUM_SPRITES   = 4,
    parameter int SETTLE_CYCLES = 20
) (
    input  logic        clock_25,
    input  logic        reset,
    input  logic [9:0]  vCount,
    input  logic        anim_en,
    output logic [31:0] cpu_oam_data,
    output logic [5:0]  cpu_oam_addr,
    output logic        cpu_write,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    localparam int             CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [5:0]     LAST_IDX    = 6'(NUM_SPRITES - 1);

    dma_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       idx_q, idx_d;
    logic [9:0]       vcount_dly_q;
    logic             vblank_edge;

    logic [7:0]       shadow_x_q [NUM_SPRITES];
    logic             dir_neg_q  [NUM_SPRITES];

    logic [31:0]      data_q, data_d;
    logic [5:0]       addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic [7:0]       frame_q, frame_d;

    logic             shadow_we;
    motion_t          cur_mot, new_mot;
    sprite_t          init_word;

    assign vblank_edge = (vCount == VBLANK_LINE) && (vcount_dly_q != VBLANK_LINE);

    // The outputs are registered from next-state values, so the ROM is addressed by idx_d:
    // the word lands on the bus in the same cycle the FSM enters the index.
    sprite_init_rom u_rom (
        .idx_i  (idx_d),
        .word_o (init_word)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SETTLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            vcount_dly_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            vcount_dly_q <= vCount;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_INIT, ST_MOVE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_IDLE: begin
                // Edges seen in any other state fall through here unhandled, i.e. dropped
                if (vblank_edge && anim_en) begin
                    state_d = ST_MOVE;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cur_mot = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (idx_d == 6'(i)) begin
                cur_mot.x   = shadow_x_q[i];
                cur_mot.neg = dir_neg_q[i];
            end
        end

        wr_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = (state_d != ST_IDLE);
        frame_d   = frame_q;
        shadow_we = 1'b0;
        new_mot   = cur_mot;

        if (state_q == ST_MOVE && state_d == ST_IDLE) begin
            frame_d = frame_q + 8'd1;
        end

        case (state_d)
            ST_INIT: begin
                wr_d        = 1'b1;
                addr_d      = idx_d;
                data_d      = init_word;
                shadow_we   = 1'b1;
                new_mot.x   = init_word.x;
                new_mot.neg = 1'b0;
            end
            ST_MOVE: begin
                new_mot   = next_motion(cur_mot);
                wr_d      = 1'b1;
                addr_d    = idx_d;
                // y, tile and palette never change after INIT, so the ROM still holds them
                data_d    = {init_word.pal, init_word.tile, init_word.y, new_mot.x};
                shadow_we = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- output and shadow registers ----------------
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b1;
            frame_q <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x_q[i] <= '0;
                dir_neg_q[i]  <= 1'b0;
            end
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (shadow_we && idx_d == 6'(i)) begin
                    shadow_x_q[i] <= new_mot.x;
                    dir_neg_q[i]  <= new_mot.neg;
                end
            end
        end
    end

    assign cpu_oam_data = data_q;
    assign cpu_oam_addr = addr_q;
    assign cpu_write    = wr_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_oam_dma_sequencer.sv
module tb_oam_dma_sequencer;

    localparam int N      = 4;
    localparam int SETTLE = 20;

    logic        clock_25 = 1'b0;
    logic        reset    = 1'b1;
    logic [9:0]  vCount   = '0;
    logic        anim_en  = 1'b0;
    logic [31:0] cpu_oam_data;
    logic [5:0]  cpu_oam_addr;
    logic        cpu_write;
    logic        busy;
    logic [7:0]  frame_cnt;

    oam_dma_sequencer #(
        .NUM_SPRITES   (N),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .vCount       (vCount),
        .anim_en      (anim_en),
        .cpu_oam_data (cpu_oam_data),
        .cpu_oam_addr (cpu_oam_addr),
        .cpu_write    (cpu_write),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
    );

    always #20 clock_25 = ~clock_25;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: a queue of scheduled OAM writes ----------------
    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        bit          last;   // final write of a motion burst
    } wr_t;

    wr_t        pend[$];
    int         settle_left;
    bit         exp_wr, exp_busy, inc_pending;
    logic [5:0] exp_addr;
    logic [31:0] exp_data;
    logic [7:0] exp_frame;
    int         prev_vc;
    int         mx   [N];
    int         mdir [N];
    int         win_writes;

    task automatic model_reset();
        pend.delete();
        settle_left = SETTLE;
        exp_wr      = 1'b0;
        exp_busy    = 1'b1;
        inc_pending = 1'b0;
        exp_addr    = '0;
        exp_data    = '0;
        exp_frame   = '0;
        prev_vc     = 0;
    endtask

    function automatic logic [31:0] word(input int i, input int x);
        return {8'd1, 8'(i), 8'd100, 8'(x)};
    endfunction

    task automatic push_init();
        for (int i = 0; i < N; i++) begin
            mx[i]   = (16 + 32 * i) % 256;
            mdir[i] = 1;
            pend.push_back('{6'(i), word(i, mx[i]), 1'b0});
        end
    endtask

    task automatic push_move();
        for (int i = 0; i < N; i++) begin
            if (mdir[i] == 1) begin
                if (mx[i] == 248) begin mx[i] = 247; mdir[i] = -1; end
                else mx[i] = mx[i] + 1;
            end else begin
                if (mx[i] == 0) begin mx[i] = 1; mdir[i] = 1; end
                else mx[i] = mx[i] - 1;
            end
            pend.push_back('{6'(i), word(i, mx[i]), i == N - 1});
        end
    endtask

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_edge();
        bit idle;
        bit ev;
        wr_t e;
        if (!reset) return;
        idle = (settle_left == 0) && (pend.size() == 0) && !exp_wr;
        if (inc_pending) begin
            exp_frame   = exp_frame + 8'd1;
            inc_pending = 1'b0;
        end
        ev      = (vCount == 10'd480) && (prev_vc != 480);
        prev_vc = int'(vCount);
        if (settle_left > 0) begin
            settle_left--;
            if (settle_left == 0) push_init();
        end else if (idle && ev && anim_en) begin
            push_move();
        end
        if (pend.size() > 0) begin
            e        = pend.pop_front();
            exp_wr   = 1'b1;
            exp_addr = e.addr;
            exp_data = e.data;
            if (e.last) inc_pending = 1'b1;
        end else begin
            exp_wr = 1'b0;
        end
        exp_busy = !((settle_left == 0) && (pend.size() == 0) && !exp_wr);
    endtask

    task automatic check_outputs();
        check("write", 32'(cpu_write), 32'(exp_wr));
        check("addr",  32'(cpu_oam_addr), 32'(exp_addr));
        check("data",  cpu_oam_data, exp_data);
        check("busy",  32'(busy), 32'(exp_busy));
        check("frame", 32'(frame_cnt), 32'(exp_frame));
    endtask

    task automatic step();
        @(posedge clock_25);
        model_edge();
        #1;
        check_outputs();
        if (cpu_write) win_writes++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_write"}, 32'(cpu_write), 32'd0);
        check({tag, "_addr"},  32'(cpu_oam_addr), 32'd0);
        check({tag, "_data"},  cpu_oam_data, 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd1);
        check({tag, "_frame"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int k;
        int guard;
        model_reset();
        #2 reset = 1'b0;
        #3;
        check_reset_values("rst0");
        repeat (3) step();
        reset = 1'b1;

        // Power-up: settle, initial table, then random traffic
        for (int c = 0; c < 60; c++) begin
            vCount  = 10'($urandom_range(0, 479));
            anim_en = 1'($urandom);
            step();
        end

        // anim_en low across three frames: nothing written
        anim_en    = 1'b0;
        win_writes = 0;
        for (int f = 0; f < 3; f++) begin
            vCount = 10'd479; repeat (5) step();
            vCount = 10'd480; repeat (5) step();
        end
        check("anim_off_writes", 32'(win_writes), 32'd0);

        // vCount held on the vblank line: exactly one burst
        vCount = 10'd479; repeat (10) step();
        anim_en    = 1'b1;
        vCount     = 10'd480;
        win_writes = 0;
        repeat (800) step();
        check("hold480_writes", 32'(win_writes), 32'(N));

        // Randomized frames: long enough to bounce sprites off both walls and wrap frame_cnt
        for (int f = 0; f < 1200; f++) begin
            anim_en = ($urandom_range(0, 9) < 8);
            vCount  = 10'd479;
            repeat ($urandom_range(1, 3)) step();
            vCount = 10'd480;
            k = $urandom_range(1, 8);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 7) == 0) anim_en = ~anim_en;
                step();
            end
            if ($urandom_range(0, 5) == 0) begin
                vCount = 10'd0;   step();
                vCount = 10'd480; step();
            end
            vCount = 10'($urandom_range(0, 479));
            repeat ($urandom_range(2, 5)) step();
        end

        // Reset in the middle of a motion burst
        vCount = 10'd479; repeat (10) step();
        anim_en = 1'b1;
        vCount  = 10'd480;
        guard   = 0;
        step();
        while (!(exp_wr && exp_addr == 6'd2) && guard < 20) begin
            step();
            guard++;
        end
        check("midburst_reached", 32'(guard < 20), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        repeat (2) step();
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            vCount  = 10'($urandom_range(0, 479));
            anim_en = 1'($urandom);
            step();
        end
        // One more accepted frame after the re-init
        vCount = 10'd479; anim_en = 1'b1; repeat (4) step();
        vCount = 10'd480; repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
